// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave register file, oversampled into axi_aclk (no SCLK clock domain).
// Optional frame counter at 0x7E/0x7F when SPI_FRAME_CNT_EN is defined.
module spi_slave_regs #(
  parameter int NREGS       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               axi_aclk,
  input  logic               axi_areset,
  input  logic               spi_sclk,
  input  logic               spi_cs_n,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic               spi_miso_t,
  output logic [NREGS*8-1:0] reg_q,
  output logic               wr_stb,
  output logic [6:0]         wr_addr,
  output logic [7:0]         wr_data,
  output logic               err_stb
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMD  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, flush;
  logic       sclk_s, cs_s, mosi_s, sclk_d, cs_d, armed;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] state;
  logic [4:0] bit_cnt;
  logic [6:0] shift_sr;
  logic       rw;
  logic [6:0] addr;
  logic [6:0] cmd_addr;
  logic [7:0] data_byte;
  logic [7:0] tx_sr;
  logic [7:0] regs [NREGS];
`ifdef SPI_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign cs_s       = cs_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign spi_miso_t = cs_s;

  // cs_n falls only count once a genuine high level has been seen after reset,
  // so a frame already in progress at reset release is skipped entirely.
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = armed & cs_d & ~cs_s;

  assign cmd_addr  = {shift_sr[5:0], mosi_s};
  assign data_byte = {shift_sr[6:0], mosi_s};

  function automatic logic in_range(input logic [6:0] a);
    return int'(a) < NREGS;
  endfunction

  function automatic logic [7:0] rd_byte(input logic [6:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NREGS; i++)
      if (a == 7'(i)) r = regs[i];
`ifdef SPI_FRAME_CNT_EN
    if (a == 7'h7E) r = frame_cnt[15:8];
    if (a == 7'h7F) r = frame_cnt[7:0];
`endif
    return r;
  endfunction

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      flush     <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      if (flush[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state    <= IDLE;
      bit_cnt  <= 5'd0;
      shift_sr <= 7'd0;
      rw       <= 1'b0;
      addr     <= 7'd0;
      tx_sr    <= 8'h00;
      spi_miso <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= 7'd0;
      wr_data  <= 8'h00;
      err_stb  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
`ifdef SPI_FRAME_CNT_EN
      frame_cnt <= 16'd0;
`endif
    end else begin
      wr_stb  <= 1'b0;
      err_stb <= 1'b0;
      case (state)
        IDLE: if (cs_fall) begin
          state    <= CMD;
          bit_cnt  <= 5'd0;
          spi_miso <= 1'b0;
        end
        CMD: if (cs_rise) begin
          state   <= IDLE;
          err_stb <= 1'b1;
        end else if (sclk_rise) begin
          shift_sr <= {shift_sr[5:0], mosi_s};
          bit_cnt  <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            rw    <= shift_sr[6];
            addr  <= cmd_addr;
            tx_sr <= shift_sr[6] ? rd_byte(cmd_addr) : 8'h00;
            state <= DATA;
          end
        end
        DATA: if (cs_rise) begin
          state    <= IDLE;
          err_stb  <= 1'b1;
          spi_miso <= 1'b0;
        end else begin
          if (sclk_fall) begin
            spi_miso <= tx_sr[7];
            tx_sr    <= {tx_sr[6:0], 1'b0};
          end
          if (sclk_rise) begin
            shift_sr <= {shift_sr[5:0], mosi_s};
            bit_cnt  <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              state <= DONE;
`ifdef SPI_FRAME_CNT_EN
              frame_cnt <= frame_cnt + 16'd1;
`endif
              if (!rw) begin
                if (in_range(addr)) begin
                  for (int i = 0; i < NREGS; i++)
                    if (addr == 7'(i)) regs[i] <= data_byte;
                  wr_stb  <= 1'b1;
                  wr_addr <= addr;
                  wr_data <= data_byte;
                end else begin
`ifdef SPI_FRAME_CNT_EN
                  if (addr < 7'h7E) err_stb <= 1'b1;
`else
                  err_stb <= 1'b1;
`endif
                end
              end
            end
          end
        end
        DONE: if (cs_rise) begin
          state    <= IDLE;
          spi_miso <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_reg_q
    assign reg_q[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: SPI master tasks, register-file model and per-cycle compare.
`timescale 1ns/1ps
module tb_spi_slave_regs;
  localparam int NREGS = 16;
  localparam int SYNC  = 2;
`ifdef SPI_FRAME_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, sclk, cs_n, mosi;
  logic         miso, miso_t, wr_stb, err_stb;
  logic [127:0] reg_q;
  logic [6:0]   wr_addr;
  logic [7:0]   wr_data;

  spi_slave_regs #(.NREGS(NREGS), .SYNC_STAGES(SYNC)) dut (
    .axi_aclk(clk), .axi_areset(rst), .spi_sclk(sclk), .spi_cs_n(cs_n),
    .spi_mosi(mosi), .spi_miso(miso), .spi_miso_t(miso_t), .reg_q(reg_q),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .err_stb(err_stb)
  );

  always #5 clk = ~clk;

  int          total = 0, bad = 0;
  int          n_wr = 0, n_err = 0;
  int          obs_wr_lat;
  logic [6:0]  cap_addr = 7'd0;
  logic [7:0]  cap_data = 8'd0;
  bit          chk_en = 1'b0;
  logic [7:0]  model_regs [NREGS];
  logic [15:0] model_cnt;
  logic [7:0]  rx;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++) r[8*i +: 8] = model_regs[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
    model_cnt = 16'd0;
  endtask

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      n_wr++;
      cap_addr = wr_addr;
      cap_data = wr_data;
    end
    if (err_stb === 1'b1) n_err++;
  end

  // Between frames the register file must match the model and no strobe may fire.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("reg_q", reg_q, model_flat());
      chk("idle_wr_stb", {127'd0, wr_stb}, 128'd0);
      chk("idle_err_stb", {127'd0, err_stb}, 128'd0);
    end
  end

  task automatic sclk_bit(input logic b, output logic m);
    mosi = b;
    #50;
    sclk = 1'b1;
    m = miso;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      if (wr_stb === 1'b1 && obs_wr_lat == 0) obs_wr_lat = c;
    end
    #16;
    sclk = 1'b0;
  endtask

  task automatic do_frame(input logic [15:0] w, input int nbits, input string nm,
                          output logic [7:0] rx_out);
    logic       complete, rd, exp_wr, exp_err, m;
    logic [6:0] a;
    logic [7:0] d, exp_rx;
    int         w0, e0;
    complete = (nbits == 16);
    rd = w[15];
    a  = w[14:8];
    d  = w[7:0];
    exp_rx = 8'h00;
    if (int'(a) < NREGS) exp_rx = model_regs[a];
    else if (CNT_EN && a == 7'h7E) exp_rx = model_cnt[15:8];
    else if (CNT_EN && a == 7'h7F) exp_rx = model_cnt[7:0];
    exp_wr  = complete && !rd && int'(a) < NREGS;
    exp_err = !complete || (!rd && int'(a) >= NREGS && !(CNT_EN && a >= 7'h7E));
    w0 = n_wr;
    e0 = n_err;
    chk_en = 1'b0;
    obs_wr_lat = 0;
    rx_out = 8'h00;
    cs_n = 1'b0;
    #50;
    for (int i = 0; i < nbits; i++) begin
      sclk_bit(w[15-i], m);
      if (i >= 8) rx_out = {rx_out[6:0], m};
    end
    #50;
    cs_n = 1'b1;
    #100;
    if (complete && rd) chk({nm, "_miso"}, {120'd0, rx_out}, {120'd0, exp_rx});
    chk({nm, "_wr_cnt"}, 128'(n_wr - w0), exp_wr ? 128'd1 : 128'd0);
    chk({nm, "_err_cnt"}, 128'(n_err - e0), exp_err ? 128'd1 : 128'd0);
    if (exp_wr) begin
      chk({nm, "_wr_addr"}, {121'd0, cap_addr}, {121'd0, a});
      chk({nm, "_wr_data"}, {120'd0, cap_data}, {120'd0, d});
      chk({nm, "_wr_lat"}, 128'(obs_wr_lat), 128'(SYNC + 1));
      model_regs[a] = d;
    end
    if (complete) model_cnt = model_cnt + 16'd1;
    chk_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic m;
    int   w0, e0;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    model_reset();
    #32;
    chk("rst_reg_q", reg_q, 128'd0);
    chk("rst_miso", {127'd0, miso}, 128'd0);
    chk("rst_miso_t", {127'd0, miso_t}, 128'd1);
    chk("rst_wr_stb", {127'd0, wr_stb}, 128'd0);
    chk("rst_wr_addr", {121'd0, wr_addr}, 128'd0);
    chk("rst_wr_data", {120'd0, wr_data}, 128'd0);
    chk("rst_err_stb", {127'd0, err_stb}, 128'd0);
    rst = 1'b0;
    #100;
    chk_en = 1'b1;

    do_frame(16'h05A5, 16, "t1", rx);
    chk("t1_reg5", {120'd0, reg_q[47:40]}, 128'hA5);
    chk("t1_others", reg_q & ~(128'hFF << 40), 128'd0);
    chk("t1_addr_lit", {121'd0, cap_addr}, 128'h05);
    chk("t1_data_lit", {120'd0, cap_data}, 128'hA5);

    do_frame(16'h8500, 16, "t2", rx);
    chk("t2_rx_lit", {120'd0, rx}, 128'hA5);
    chk("t2_reg5", {120'd0, reg_q[47:40]}, 128'hA5);

    do_frame(16'h4033, 16, "t3w", rx);
    do_frame(16'hC000, 16, "t3r", rx);
    chk("t3_rx_lit", {120'd0, rx}, 128'h00);

    do_frame(16'h0377, 10, "t4a", rx);
    chk("t4_reg3_abort", {120'd0, reg_q[31:24]}, 128'h00);
    do_frame(16'h0377, 16, "t4b", rx);
    chk("t4_reg3_lit", {120'd0, reg_q[31:24]}, 128'h77);

    // Reset in the middle of a frame with cs_n held low.
    w0 = n_wr;
    e0 = n_err;
    chk_en = 1'b0;
    cs_n = 1'b0;
    #50;
    for (int i = 0; i < 12; i++) sclk_bit(1'(16'h07FF >> (15 - i)), m);
    #10;
    rst = 1'b1;
    #10;
    chk("t5_rst_reg_q", reg_q, 128'd0);
    chk("t5_rst_miso_t", {127'd0, miso_t}, 128'd1);
    chk("t5_rst_wr_stb", {127'd0, wr_stb}, 128'd0);
    model_reset();
    #10;
    rst = 1'b0;
    #10;
    for (int i = 12; i < 16; i++) sclk_bit(1'(16'h07FF >> (15 - i)), m);
    #50;
    cs_n = 1'b1;
    #100;
    chk("t5_reg7_zero", {120'd0, reg_q[63:56]}, 128'h00);
    chk("t5_no_wr", 128'(n_wr - w0), 128'd0);
    chk("t5_no_err", 128'(n_err - e0), 128'd0);
    chk_en = 1'b1;
    do_frame(16'h07FF, 16, "t5b", rx);
    chk("t5_reg7_lit", {120'd0, reg_q[63:56]}, 128'hFF);

    do_frame(16'h0111, 16, "t6w1", rx);
    do_frame(16'h0222, 16, "t6w2", rx);
    do_frame(16'hFF00, 16, "t6lo", rx);
    chk("t6_cnt_lo_lit", {120'd0, rx}, CNT_EN ? 128'h03 : 128'h00);
    do_frame(16'hFE00, 16, "t6hi", rx);
    chk("t6_cnt_hi_lit", {120'd0, rx}, 128'h00);
    do_frame(16'h7F12, 16, "t6wr", rx);
    do_frame(16'hFF00, 16, "t6lo2", rx);
    chk("t6_cnt_lo2_lit", {120'd0, rx}, CNT_EN ? 128'h06 : 128'h00);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
